// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART TX FIFO write port between N_REQ byte-stream
// requesters. Round-robin grant, locked for a whole packet (until a byte marked
// last is written), with eviction of an owner that goes silent mid-packet.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// S_IDLE | no owner; pick the next valid requester after grant_id
// S_XFER | grant_id owns the FIFO port until its last byte or idle timeout
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int GNT_W        = 2,
  parameter int IDLE_TIMEOUT = 1024,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_last,
  output logic [N_REQ-1:0]     req_ready,
  input  logic                 tx_fifo_full,
  output logic                 tx_fifo_wr_en,
  output logic [7:0]           tx_fifo_din,
  output logic                 busy,
  output logic [GNT_W-1:0]     grant_id,
  output logic                 abort_pulse,
  output logic [CNT_W-1:0]     pkt_count
);

  localparam int IDLE_W = (IDLE_TIMEOUT > 2) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);

  typedef enum logic {S_IDLE, S_XFER} state_t;

  state_t            state, state_nxt;
  logic [IDLE_W-1:0] idle_cnt;
  logic              pick_vld;
  logic [GNT_W-1:0]  pick_id;
  int                best_dist;
  logic              own_valid;
  logic              own_last;
  logic [7:0]        own_data;

  // Select the current owner's valid/last/data lanes.
  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = 8'h00;
    for (int i = 0; i < N_REQ; i++) begin
      if (GNT_W'(i) == grant_id) begin
        own_valid = req_valid[i];
        own_last  = req_last[i];
        own_data  = req_data[8*i +: 8];
      end
    end
  end

  // Round-robin pick: the valid requester at the smallest distance after grant_id
  // wins, so the previous owner is always the last candidate.
  always_comb begin
    pick_vld  = 1'b0;
    pick_id   = grant_id;
    best_dist = N_REQ;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_valid[i] &&
          ((i + 2*N_REQ - int'(grant_id) - 1) % N_REQ) < best_dist) begin
        pick_vld  = 1'b1;
        pick_id   = GNT_W'(i);
        best_dist = (i + 2*N_REQ - int'(grant_id) - 1) % N_REQ;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state: arbitrate in IDLE, leave XFER on last byte written or eviction.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (pick_vld) state_nxt = S_XFER;
      S_XFER: if ((tx_fifo_wr_en && own_last) || abort_pulse) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs: only the owner sees ready, and only while the FIFO has room.
  always_comb begin
    req_ready     = '0;
    tx_fifo_wr_en = 1'b0;
    tx_fifo_din   = 8'h00;
    busy          = 1'b0;
    abort_pulse   = 1'b0;
    if (state == S_XFER) begin
      busy = 1'b1;
      for (int i = 0; i < N_REQ; i++) begin
        if (GNT_W'(i) == grant_id) req_ready[i] = !tx_fifo_full;
      end
      tx_fifo_wr_en = own_valid && !tx_fifo_full;
      if (tx_fifo_wr_en) tx_fifo_din = own_data;
      abort_pulse = !own_valid && (idle_cnt == IDLE_LAST);
    end
  end

  // Grant register, silent-owner counter and completed-packet counter.
  // A full stall with valid held high is not silence, so the counter holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_id  <= GNT_W'(N_REQ - 1);
      idle_cnt  <= '0;
      pkt_count <= '0;
    end else begin
      if (state == S_IDLE) begin
        idle_cnt <= '0;
        if (pick_vld) grant_id <= pick_id;
      end else begin
        if (tx_fifo_wr_en || abort_pulse) idle_cnt <= '0;
        else if (!own_valid)              idle_cnt <= idle_cnt + IDLE_W'(1);
        if (tx_fifo_wr_en && own_last)    pkt_count <= pkt_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: cycle model of the sharing rules checked on every
// falling edge, plus directed scenarios with literal expectations.
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int T = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]   req_valid, req_last, req_ready;
  logic [8*N-1:0] req_data;
  logic           full = 1'b0;
  logic           wr_en, busy, abort;
  logic [7:0]     din;
  logic [1:0]     gid;
  logic [15:0]    pkt;

  logic       tv [N];
  logic [7:0] td [N];
  logic       tl [N];

  always_comb begin
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    for (int i = 0; i < N; i++) begin
      req_valid[i]        = tv[i];
      req_last[i]         = tl[i];
      req_data[8*i +: 8]  = td[i];
    end
  end

  uart_tx_arbiter #(.N_REQ(N), .GNT_W(2), .IDLE_TIMEOUT(T), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_fifo_full(full),
    .tx_fifo_wr_en(wr_en), .tx_fifo_din(din), .busy(busy), .grant_id(gid),
    .abort_pulse(abort), .pkt_count(pkt));

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tmo(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: wait bound expired (cycle %0d)", nm, cyc);
  endtask

  // Model: whether someone owns the port, who owns it (or owned it last),
  // how many cycles the owner has been silent, packets completed.
  bit  m_busy  = 1'b0;
  int  m_owner = N - 1;
  int  m_quiet = 0;
  int  m_pkts  = 0;

  logic [7:0] wr_log[$];
  int         wr_cyc[$];
  int         abort_cyc[$];
  int         stall_cyc = 0;

  task automatic clear_logs();
    wr_log.delete();
    wr_cyc.delete();
    abort_cyc.delete();
    stall_cyc = 0;
  endtask

  always @(negedge clk) begin
    logic [N-1:0] e_ready;
    logic         e_wr, e_abort, found;
    logic [7:0]   e_din;
    cyc++;
    if (!rst_n) begin
      chk("rst_busy", busy, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_din", din, 0);
      chk("rst_ready", req_ready, 0);
      chk("rst_grant", gid, N - 1);
      chk("rst_abort", abort, 0);
      chk("rst_pkt", pkt, 0);
      m_busy = 0; m_owner = N - 1; m_quiet = 0; m_pkts = 0;
    end else begin
      e_ready = '0; e_wr = 0; e_din = 8'h00; e_abort = 0;
      if (m_busy) begin
        if (!full) e_ready[m_owner] = 1'b1;
        e_wr = tv[m_owner] && !full;
        if (e_wr) e_din = td[m_owner];
        e_abort = !tv[m_owner] && (m_quiet + 1 == T);
      end
      chk("busy", busy, m_busy);
      chk("grant_id", gid, m_owner);
      chk("req_ready", req_ready, e_ready);
      chk("wr_en", wr_en, e_wr);
      chk("din", din, e_din);
      chk("abort", abort, e_abort);
      chk("pkt_count", pkt, m_pkts);
      if (wr_en) begin wr_log.push_back(din); wr_cyc.push_back(cyc); end
      if (abort) abort_cyc.push_back(cyc);
      if (busy && full && !wr_en) stall_cyc++;
      if (!m_busy) begin
        found = 0;
        for (int k = 1; k <= N; k++) begin
          if (!found && tv[(m_owner + k) % N]) begin
            found = 1;
            m_owner = (m_owner + k) % N;
            m_busy = 1; m_quiet = 0;
          end
        end
      end else if (e_wr) begin
        m_quiet = 0;
        if (tl[m_owner]) begin m_pkts = (m_pkts + 1) % 65536; m_busy = 0; end
      end else if (!tv[m_owner]) begin
        m_quiet++;
        if (m_quiet == T) begin m_busy = 0; m_quiet = 0; end
      end
    end
  end

  task automatic reset_dut();
    for (int i = 0; i < N; i++) begin tv[i] = 0; tl[i] = 0; td[i] = 8'h00; end
    full = 0;
    @(posedge clk); #1 rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    clear_logs();
  endtask

  // Present up to 4 bytes (byte j in bits [8j+7:8j]) and hold each until accepted.
  task automatic send_pkt(input int id, input logic [31:0] bytes, input int len, input bit end_last);
    int budget;
    for (int j = 0; j < len; j++) begin
      td[id] = bytes[8*j +: 8];
      tl[id] = end_last && (j == len - 1);
      tv[id] = 1;
      budget = 0;
      do begin @(negedge clk); budget++; end while (!req_ready[id] && budget < 200);
      if (!req_ready[id]) tmo($sformatf("send_req%0d_byte%0d", id, j));
      @(posedge clk); #1;
    end
    tv[id] = 0; tl[id] = 0; td[id] = 8'h00;
  endtask

  task automatic wait_writes(input int n, input string nm);
    int budget = 0;
    while (wr_log.size() < n && budget < 300) begin @(posedge clk); budget++; end
    if (wr_log.size() < n) tmo(nm);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0;
    for (int i = 0; i < N; i++) begin tv[i] = 0; tl[i] = 0; td[i] = 8'h00; end
    repeat (3) @(posedge clk);

    // 1: req0 three-byte packet, FIFO never full
    reset_dut();
    c0 = cyc + 1;
    send_pkt(0, 32'h00A2A1A0, 3, 1);
    repeat (2) @(negedge clk);
    chk("t1_nwr", wr_log.size(), 3);
    chk("t1_b0", wr_log[0], 8'hA0);
    chk("t1_b1", wr_log[1], 8'hA1);
    chk("t1_b2", wr_log[2], 8'hA2);
    chk("t1_first_cyc", wr_cyc[0], c0 + 1);
    chk("t1_last_cyc", wr_cyc[2], c0 + 3);
    chk("t1_pkt", pkt, 1);
    chk("t1_busy_after", busy, 0);

    // 2: all four requesters at once, two bytes each
    reset_dut();
    c0 = cyc + 1;
    fork
      send_pkt(0, 32'h00001110, 2, 1);
      send_pkt(1, 32'h00002120, 2, 1);
      send_pkt(2, 32'h00003130, 2, 1);
      send_pkt(3, 32'h00004140, 2, 1);
    join
    repeat (2) @(negedge clk);
    chk("t2_nwr", wr_log.size(), 8);
    for (int k = 0; k < 8; k++)
      chk($sformatf("t2_byte%0d", k), wr_log[k], 16 * (k / 2 + 1) + (k % 2));
    chk("t2_first_cyc", wr_cyc[0], c0 + 1);
    for (int k = 1; k < 8; k++)
      chk($sformatf("t2_gap%0d", k), wr_cyc[k] - wr_cyc[k-1], (k % 2) ? 1 : 2);
    chk("t2_pkt", pkt, 4);

    // 3: req1 stalled 50 cycles by a full FIFO mid-packet
    reset_dut();
    fork
      send_pkt(1, 32'h54535251, 4, 1);
      begin
        wait_writes(2, "t3_wait2");
        #1 full = 1;
        repeat (50) @(posedge clk);
        #1 full = 0;
      end
    join
    repeat (2) @(negedge clk);
    chk("t3_nwr", wr_log.size(), 4);
    chk("t3_b0", wr_log[0], 8'h51);
    chk("t3_b1", wr_log[1], 8'h52);
    chk("t3_b2", wr_log[2], 8'h53);
    chk("t3_b3", wr_log[3], 8'h54);
    chk("t3_stall_len", stall_cyc, 50);
    chk("t3_gap", wr_cyc[2] - wr_cyc[1], 51);
    chk("t3_aborts", abort_cyc.size(), 0);
    chk("t3_pkt", pkt, 1);

    // 4: req2 goes silent after one byte, req3 waiting
    reset_dut();
    fork
      send_pkt(2, 32'h00000061, 1, 0);
      send_pkt(3, 32'h00000071, 1, 1);
    join
    repeat (2) @(negedge clk);
    chk("t4_aborts", abort_cyc.size(), 1);
    chk("t4_abort_delay", abort_cyc[0] - wr_cyc[0], 16);
    chk("t4_nwr", wr_log.size(), 2);
    chk("t4_b0", wr_log[0], 8'h61);
    chk("t4_b1", wr_log[1], 8'h71);
    chk("t4_regrant", wr_cyc[1] - abort_cyc[0], 2);
    chk("t4_pkt", pkt, 1);

    // 5: async reset during req0's second byte
    reset_dut();
    send_pkt(1, 32'h00000091, 1, 1);
    tv[0] = 1; td[0] = 8'hA0; tl[0] = 0;
    wait_writes(2, "t5_wait_a0");
    #1 td[0] = 8'hA1;
    #2 rst_n = 0;
    #1;
    chk("t5_async_wr_en", wr_en, 0);
    chk("t5_async_busy", busy, 0);
    chk("t5_async_grant", gid, 3);
    chk("t5_async_ready", req_ready, 0);
    chk("t5_async_din", din, 0);
    chk("t5_async_pkt", pkt, 0);
    tv[0] = 0; td[0] = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    clear_logs();
    fork
      send_pkt(3, 32'h00000081, 1, 1);
      send_pkt(0, 32'h000000A5, 1, 1);
    join
    repeat (2) @(negedge clk);
    chk("t5_nwr", wr_log.size(), 2);
    chk("t5_first_owner_byte", wr_log[0], 8'hA5);
    chk("t5_second_byte", wr_log[1], 8'h81);
    chk("t5_pkt", pkt, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
